seq_detect_ctrl: RTL
====================

// Module: seq_detect_ctrl
// PURPOSE
//  Programmable serial pattern-detector controller. Holds a runtime-loadable pattern, length and
//  overlap mode, runs detection on a qualified bit stream, counts matches and stops at a
//  programmable target. Sits between the host/config bus and the serial input it watches.
//  Supersedes the fixed-pattern Mealy detectors for any pattern of 1..MAX_LEN bits.
// PARAMETERS
//  MAX_LEN  8  longest supported pattern, in bits (>=2)
//  LEN_W    4  width of cfg_len; must hold MAX_LEN ($clog2(MAX_LEN)+1)
//  CNT_W    8  width of match_count and cfg_target
// PORTS
//  clk          in   1        single clock, rising edge
//  reset        in   1        synchronous, active-high
//  cfg_valid    in   1        config request
//  cfg_ready    out  1        config can be accepted (high only in IDLE)
//  cfg_pattern  in   MAX_LEN  pattern; bit[len-1] is the first bit received, bit[0] the last
//  cfg_len      in   LEN_W    pattern length, 1..MAX_LEN
//  cfg_overlap  in   1        1 = overlapping detection, 0 = non-overlapping
//  cfg_target   in   CNT_W    matches to reach before DONE; 0 = run indefinitely
//  cfg_err      out  1        1-cycle pulse: config rejected (len 0 or len > MAX_LEN)
//  start        in   1        begin/restart a detection run
//  stop         in   1        abort to IDLE
//  in_valid     in   1        the bit on 'in' is sampled this cycle
//  in           in   1        serial data bit
//  match        out  1        1-cycle pulse, registered, one per detected pattern
//  match_count  out  CNT_W    matches in current/last run, saturates at all-ones
//  busy         out  1        state == RUN
//  done         out  1        state == DONE (target reached), level
// BEHAVIOUR
//  - Reset: state IDLE; match, cfg_err, busy, done = 0; match_count = 0; window and fill = 0;
//    config = pattern 'b0110, len 4, overlap 1, target 0. cfg_ready = 1 from the first
//    post-reset cycle.
//  - States: IDLE, RUN, DONE. IDLE -start-> RUN; RUN -target hit-> DONE; RUN/DONE -stop-> IDLE;
//    DONE -start-> RUN. stop beats start when both are high. Both are ignored during reset.
//  - Config: the accept condition is cfg_valid & cfg_ready. If len is valid, all cfg_* are latched.
//    Otherwise cfg_err pulses the next cycle and the stored config is unchanged.
//    cfg_valid is ignored outside IDLE.
//  - Entering RUN (from IDLE or DONE) clears window, fill and match_count. The first sample is
//    taken in the cycle after the start cycle.
//  - In RUN, each in_valid cycle does: window <= {window[MAX_LEN-2:0], in};
//    fill <= min(fill+1, MAX_LEN).
//  - Hit condition, evaluated on the updated window: fill_next >= len and
//    window_next[len-1:0] == pattern[len-1:0].
//    On a hit, match = 1 and match_count += 1 (saturating) on the next edge, so latency = 1 cycle.
//  - After a hit: with overlap = 1, fill is kept. With overlap = 0, fill <= 0, so older bits
//    cannot be reused.
//  - If target != 0 and the new count == target: DONE is entered on the same edge that raises
//    match. In DONE, in_valid is ignored and match_count holds.
//  - in_valid together with stop: the bit is discarded. in_valid together with start in DONE:
//    the bit is discarded.
//  - stop keeps match_count until the next start. Sync reset mid-run forces the reset state on
//    that edge.
//  - match_count saturation: a count stuck at all-ones never equals a larger target, so the
//    block keeps running. Targets are <= 2^CNT_W - 1 by width.
// STRUCTURE
//  - Package seq_det_pkg: state enum {IDLE, RUN, DONE}; reset-default pattern, len and overlap
//    constants.
//  - Sub-module seq_match_window: shift window, fill counter, masked compare. Inputs: shift_en,
//    clr_fill, clr_all, pattern, len. Output: hit (combinational on next window).
//  - Top holds the FSM, config registers, counter and output registers.
// TESTING
//  1. Defaults, overlap: start, stream 0110110 -> match pulses 1 cycle after the 4th and 7th
//     bits; count = 2.
//  2. Config pattern 'b0110, len 4, overlap 0; stream 0110110 -> a single match, after the
//     4th bit; count = 1.
//  3. Config len 3, pattern 'b101, target 2; stream 10101 -> matches after bits 3 and 5;
//     done = 1 with the second match; further bits ignored.
//  4. cfg_len 0, then 9 (MAX_LEN 8) -> cfg_err pulses each time; a following run still
//     detects 0110.
//  5. In RUN, cfg_valid -> cfg_ready = 0, no effect. stop with in_valid -> bit dropped, IDLE,
//     count kept. start -> count = 0.
//  6. reset asserted mid-pattern (after 011) -> next cycle: IDLE, outputs 0, defaults restored,
//     no match produced.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and reset-default configuration for the serial pattern detector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, default pattern/length/overlap applied at reset.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Reset-default config: pattern 0110, 4 bits long, overlapping detection.
  localparam logic [31:0] DEF_PATTERN = 32'b0110;
  localparam int          DEF_LEN     = 4;
  localparam logic        DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/seq_match_window.sv
// Shift window + fill counter + masked compare against a programmable pattern.
// Latency: hit is combinational on the window value the current shift produces.
// Backpressure: none; a bit is consumed on every cycle shift_en is high.
//
// Ports: clk, reset (sync, active-high); shift_en/in_bit shift one bit in;
//        clr_fill empties the fill count on this shift; clr_all clears window and fill;
//        pattern/len select the compared bits; hit flags a match on the next window.
module seq_match_window #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               shift_en,
  input  logic               in_bit,
  input  logic               clr_fill,
  input  logic               clr_all,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] window_next;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill;
  logic [LEN_W-1:0]   fill_next;

  always_comb begin
    window_next = {window[MAX_LEN-2:0], in_bit};
    // fill saturates at MAX_LEN: it only needs to tell whether len bits are present.
    if (fill >= LEN_W'(MAX_LEN)) fill_next = LEN_W'(MAX_LEN);
    else                         fill_next = fill + LEN_W'(1);
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit = shift_en && (fill_next >= len) && (((window_next ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset || clr_all) begin
      window <= '0;
      fill   <= '0;
    end else if (shift_en) begin
      window <= window_next;
      // Non-overlapping mode empties fill after a hit so consumed bits are never reused.
      fill   <= clr_fill ? '0 : fill_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern-detector controller: config regs, IDLE/RUN/DONE FSM, match counter.
// Latency: match pulses 1 cycle after the sampled bit that completes the pattern.
// Backpressure: cfg_ready low outside IDLE (config ignored); in_valid ignored outside RUN.
//
// Ports: clk, reset (sync, active-high); cfg_valid/cfg_ready handshake with cfg_pattern,
//        cfg_len, cfg_overlap, cfg_target and cfg_err (reject pulse); start/stop run control;
//        in_valid/in serial stream; match pulse, match_count, busy (RUN), done (DONE).
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               stop,
  input  logic               in_valid,
  input  logic               in,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic [CNT_W-1:0]   tgt_q;

  logic               cfg_accept;
  logic               len_ok;
  logic               go_run;
  logic               shift_en;
  logic               hit;
  logic [CNT_W-1:0]   count_inc;
  logic               target_hit;

  assign cfg_ready  = (state == IDLE);
  assign cfg_accept = cfg_valid && cfg_ready;
  assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

  // stop beats start; start while already running is not a restart.
  assign go_run   = start && !stop && (state != RUN);
  // A bit arriving together with stop is dropped.
  assign shift_en = (state == RUN) && in_valid && !stop;

  assign count_inc  = (match_count == '1) ? match_count : match_count + CNT_W'(1);
  // A saturated count never reaches a larger target, so the run simply continues.
  assign target_hit = (tgt_q != '0) && (count_inc == tgt_q);

  seq_match_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .in_bit   (in),
    .clr_fill (hit && !ovl_q),
    .clr_all  (go_run),
    .pattern  (pat_q),
    .len      (len_q),
    .hit      (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pat_q       <= DEF_PATTERN[MAX_LEN-1:0];
      len_q       <= LEN_W'(DEF_LEN);
      ovl_q       <= DEF_OVERLAP;
      tgt_q       <= '0;
      match       <= 1'b0;
      match_count <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      match   <= 1'b0;
      cfg_err <= cfg_accept && !len_ok;

      if (cfg_accept && len_ok) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
        tgt_q <= cfg_target;
      end

      case (state)
        IDLE: begin
          if (go_run) begin
            state       <= RUN;
            busy        <= 1'b1;
            match_count <= '0;
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (hit) begin
            match       <= 1'b1;
            match_count <= count_inc;
            if (target_hit) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (stop) begin
            state <= IDLE;
            done  <= 1'b0;
          end else if (start) begin
            state       <= RUN;
            busy        <= 1'b1;
            done        <= 1'b0;
            match_count <= '0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
